// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control unit: Moore sequencer, NZCV flag register,
// condition evaluation and per-state datapath controls.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter bit COND_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [3:0]            alu_flags,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            reg_src,
  output logic [3:0]            flags,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_LSL = 3'd4;
  localparam logic [2:0] ALU_LSR = 3'd5;

  state_t     st, st_nx;
  logic       pass, cond_ex, cond_ex_q;
  logic [2:0] dp_alu, alu_c;
  logic       dp_wb, dp_cmp, flag_upd;
  logic       pc_w, ir_w, mem_w, reg_w;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = !z;
      4'b0010: pass = c;
      4'b0011: pass = !c;
      4'b0100: pass = n;
      4'b0101: pass = !n;
      4'b0110: pass = v;
      4'b0111: pass = !v;
      4'b1000: pass = c & !z;
      4'b1001: pass = !c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = !z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  assign cond_ex = COND_CHECK ? pass : 1'b1;

  always_comb begin
    dp_alu = ALU_ADD;
    dp_wb  = 1'b1;
    dp_cmp = 1'b0;
    case (funct[4:1])
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b1101: dp_alu = ALU_LSL;
      4'b1110: dp_alu = ALU_LSR;
      4'b1010: begin
        dp_alu = ALU_SUB;
        dp_wb  = 1'b0;
        dp_cmp = 1'b1;
      end
      default: dp_wb = 1'b0;
    endcase
  end

  // Unknown cmds neither write back nor touch the flags, even with S set
  assign flag_upd = (st == S_EXECR || st == S_EXECI) & cond_ex_q
                  & ((funct[0] & dp_wb) | dp_cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_FETCH;
      flags     <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      st <= st_nx;
      if (st == S_DECODE)
        cond_ex_q <= cond_ex;
      if (flag_upd)
        flags <= alu_flags;
    end
  end

  always_comb begin
    st_nx      = S_FETCH;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    imm_src    = 2'd0;
    alu_c      = ALU_ADD;
    case (st)
      S_FETCH: begin
        st_nx      = S_DECODE;
        ir_w       = 1'b1;
        pc_w       = 1'b1;
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
      end
      S_DECODE: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        case (op)
          2'b00:   st_nx = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   st_nx = S_MEMADR;
          2'b10:   st_nx = S_BRANCH;
          default: st_nx = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        st_nx     = funct[0] ? S_MEMRD : S_MEMWR;
        alu_src_b = 2'd1;
        imm_src   = 2'd1;
        alu_c     = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: begin
        st_nx   = S_MEMWB;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'd1;
        reg_w      = cond_ex_q & (rd != 4'hF);
        pc_w       = cond_ex_q & (rd == 4'hF);
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = cond_ex_q;
      end
      S_EXECR: begin
        st_nx = S_ALUWB;
        alu_c = dp_alu;
      end
      S_EXECI: begin
        st_nx     = S_ALUWB;
        alu_src_b = 2'd1;
        alu_c     = dp_alu;
      end
      S_ALUWB: begin
        reg_w = dp_wb & cond_ex_q & (rd != 4'hF);
        pc_w  = dp_wb & cond_ex_q & (rd == 4'hF);
      end
      S_BRANCH: begin
        alu_src_b  = 2'd1;
        imm_src    = 2'd2;
        result_src = 2'd2;
        pc_w       = cond_ex_q;
      end
      default: st_nx = S_FETCH;
    endcase
  end

  assign pc_write    = pc_w & ~rst;
  assign ir_write    = ir_w & ~rst;
  assign mem_write   = mem_w & ~rst;
  assign reg_write   = reg_w & ~rst;
  assign alu_control = ALU_CTRL_W'(alu_c);
  assign reg_src     = {op == 2'b01, op == 2'b10};
  assign state       = st;

endmodule
